// File: rtl/audio_stream_pkg.sv
// Shared parameter defaults and width helpers for the audio_stream sample FIFO.
package audio_stream_pkg;

    localparam int DEF_CLK_HZ   = 74250000;
    localparam int DEF_RATE_HZ  = 48000;
    localparam int DEF_CHANNELS = 2;
    localparam int DEF_SAMPLE_W = 16;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_HOLD     = 1;
    localparam int DEF_ACC_W    = 32;

    // Occupancy counter must represent 0..DEPTH inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int ch_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/audio_stream_if.sv
// CPU write side and audio output side of audio_stream, bundled as one port.
interface audio_stream_if
    import audio_stream_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int DEPTH    = DEF_DEPTH
) ();

    logic                         enable;
    logic                         wr;
    logic [SAMPLE_W-1:0]          wdata;
    logic                         frame_rst;
    logic                         clr_flags;
    logic [level_w(DEPTH)-1:0]    level;
    logic                         full;
    logic                         overflow;
    logic                         underrun;
    logic                         audio_w;
    logic [CHANNELS*SAMPLE_W-1:0] audio;

    modport master (
        output enable, wr, wdata, frame_rst, clr_flags,
        input  level, full, overflow, underrun, audio_w, audio
    );

    modport slave (
        input  enable, wr, wdata, frame_rst, clr_flags,
        output level, full, overflow, underrun, audio_w, audio
    );

endinterface

// File: rtl/audio_stream_frame_fifo.sv
// Synchronous frame FIFO with registered level/full and same-cycle push+pop at full.
module frame_fifo
    import audio_stream_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          wdata,
    output logic [WIDTH-1:0]          rdata,
    output logic                      push_ok,
    output logic                      pop_ok,
    output logic [level_w(DEPTH)-1:0] level,
    output logic                      full
);

    localparam int LEVEL_W = level_w(DEPTH);
    localparam int AW      = $clog2(DEPTH);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_ptr;
    logic [LEVEL_W-1:0] level_next;

    // A pop frees the head slot in the same cycle, so a full FIFO still takes a push.
    assign pop_ok  = pop & (level != '0);
    assign push_ok = push & (~full | pop_ok);
    assign rdata   = mem[rd_ptr];

    // NOTE: default assignment first so no path leaves level_next unassigned (no latch).
    always_comb begin
        level_next = level;
        case ({push_ok, pop_ok})
            2'b10:   level_next = level + 1'b1;
            2'b01:   level_next = level - 1'b1;
            default: level_next = level;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            level <= level_next;
            full  <= (level_next == LEVEL_W'(DEPTH));
        end
    end

    // NOTE: storage is not reset; pointers and level define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/audio_stream.sv
// CPU-fed multichannel audio frame streamer: assembles frames, buffers them, and
// releases one per sample tick from a drift-free fractional rate accumulator.
module audio_stream
    import audio_stream_pkg::*;
#(
    parameter int CLK_HZ   = DEF_CLK_HZ,
    parameter int RATE_HZ  = DEF_RATE_HZ,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int HOLD     = DEF_HOLD,
    parameter int ACC_W    = DEF_ACC_W
) (
    input  logic          clk,
    input  logic          reset,
    audio_stream_if.slave bus
);

    localparam int FRAME_W = CHANNELS * SAMPLE_W;
    localparam int LEVEL_W = level_w(DEPTH);
    localparam int CH_W    = ch_w(CHANNELS);

    localparam logic signed [ACC_W-1:0] STEP_UP   = ACC_W'(RATE_HZ);
    localparam logic signed [ACC_W-1:0] STEP_DOWN = ACC_W'(RATE_HZ - CLK_HZ);
    localparam logic [CH_W-1:0]         LAST_CH   = CH_W'(CHANNELS - 1);

    logic signed [ACC_W-1:0] acc;
    logic                    tick;
    logic [CH_W-1:0]         ch;
    logic [FRAME_W-1:0]      asm_frame;
    logic [FRAME_W-1:0]      next_frame;
    logic [FRAME_W-1:0]      last_frame;
    logic [FRAME_W-1:0]      audio_q;
    logic [FRAME_W-1:0]      fifo_rdata;
    logic                    wr_eff;
    logic                    commit;
    logic                    push_ok;
    logic                    pop_ok;
    logic                    overflow_q;
    logic                    underrun_q;
    logic                    audio_w_q;
    logic [LEVEL_W-1:0]      fifo_level;
    logic                    fifo_full;

    // Bresenham-style phase: sign bit clear means a sample period has elapsed.
    always_ff @(posedge clk) begin
        if (reset)               acc <= '0;
        else if (acc[ACC_W-1])   acc <= acc + STEP_UP;
        else                     acc <= acc + STEP_DOWN;
    end

    assign tick   = bus.enable & ~acc[ACC_W-1];
    assign wr_eff = bus.wr & ~bus.frame_rst;
    assign commit = wr_eff & (ch == LAST_CH);

    // The committed frame must include the sample arriving on the final slot.
    always_comb begin
        next_frame = asm_frame;
        next_frame[ch*SAMPLE_W +: SAMPLE_W] = bus.wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ch        <= '0;
            asm_frame <= '0;
        end else if (bus.frame_rst) begin
            ch <= '0;
        end else if (bus.wr) begin
            asm_frame <= next_frame;
            ch        <= (ch == LAST_CH) ? '0 : ch + 1'b1;
        end
    end

    frame_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (commit),
        .pop     (tick),
        .wdata   (next_frame),
        .rdata   (fifo_rdata),
        .push_ok (push_ok),
        .pop_ok  (pop_ok),
        .level   (fifo_level),
        .full    (fifo_full)
    );

    // Sticky flags: a same-cycle set event overrides clr_flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
            audio_w_q  <= 1'b0;
            audio_q    <= '0;
            last_frame <= '0;
        end else begin
            overflow_q <= (overflow_q & ~bus.clr_flags) | (commit & ~push_ok);
            underrun_q <= (underrun_q & ~bus.clr_flags) | (tick & ~pop_ok);
            audio_w_q  <= tick;
            if (pop_ok) begin
                audio_q    <= fifo_rdata;
                last_frame <= fifo_rdata;
            end else if (tick) begin
                audio_q <= (HOLD != 0) ? last_frame : '0;
            end
        end
    end

    assign bus.level    = fifo_level;
    assign bus.full     = fifo_full;
    assign bus.overflow = overflow_q;
    assign bus.underrun = underrun_q;
    assign bus.audio_w  = audio_w_q;
    assign bus.audio    = audio_q;

endmodule

// File: tb/tb_audio_stream.sv
// Self-checking bench: two audio_stream configurations against a queue-based model.
module tb_audio_stream;
    import audio_stream_pkg::*;

    localparam int C0 = 2, W0 = 16, D0 = 16, H0 = 1, CK0 = 1000, R0 = 48;
    localparam int C1 = 4, W1 = 24, D1 = 4,  H1 = 0, CK1 = 60,   R1 = 7;

    typedef logic [191:0] frame_t;
    typedef struct packed { int c; int w; int d; int hold; int clk_hz; int rate_hz; } cfg_t;

    logic        clk = 1'b0;
    logic        rst  [2];
    logic        en   [2];
    logic        wr   [2];
    logic        frst [2];
    logic        clr  [2];
    logic [31:0] wd   [2];

    int checks   = 0;
    int failures = 0;

    audio_stream_if #(.CHANNELS(C0), .SAMPLE_W(W0), .DEPTH(D0)) bus0 ();
    audio_stream_if #(.CHANNELS(C1), .SAMPLE_W(W1), .DEPTH(D1)) bus1 ();

    assign bus0.enable    = en[0];
    assign bus0.wr        = wr[0];
    assign bus0.wdata     = wd[0][W0-1:0];
    assign bus0.frame_rst = frst[0];
    assign bus0.clr_flags = clr[0];
    assign bus1.enable    = en[1];
    assign bus1.wr        = wr[1];
    assign bus1.wdata     = wd[1][W1-1:0];
    assign bus1.frame_rst = frst[1];
    assign bus1.clr_flags = clr[1];

    audio_stream #(.CLK_HZ(CK0), .RATE_HZ(R0), .CHANNELS(C0), .SAMPLE_W(W0),
                   .DEPTH(D0), .HOLD(H0), .ACC_W(32))
        dut0 (.clk(clk), .reset(rst[0]), .bus(bus0));

    audio_stream #(.CLK_HZ(CK1), .RATE_HZ(R1), .CHANNELS(C1), .SAMPLE_W(W1),
                   .DEPTH(D1), .HOLD(H1), .ACC_W(32))
        dut1 (.clk(clk), .reset(rst[1]), .bus(bus1));

    always #5 clk = ~clk;

    function automatic cfg_t cfg(int i);
        cfg_t r;
        if (i == 0) r = '{C0, W0, D0, H0, CK0, R0};
        else        r = '{C1, W1, D1, H1, CK1, R1};
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    longint acc_m   [2];
    int     ch_m    [2];
    frame_t asm_m   [2];
    frame_t last_m  [2];
    frame_t audio_m [2];
    bit     ovf_m   [2];
    bit     und_m   [2];
    bit     aw_m    [2];
    frame_t q_m     [2][$];
    bit     model_ok = 1'b0;

    task automatic model_step(int i, bit rst_i, bit en_i, bit wr_i, bit frst_i, bit clr_i,
                              logic [31:0] wd_i);
        cfg_t   c      = cfg(i);
        bit     tick   = en_i && (acc_m[i] >= 0);
        bit     wr_e   = wr_i && !frst_i;
        bit     commit = wr_e && (ch_m[i] == c.c - 1);
        int     sz     = q_m[i].size();
        bit     do_pop = tick && (sz > 0);
        bit     accept = commit && ((sz < c.d) || do_pop);
        frame_t mask   = (frame_t'(1) << c.w) - frame_t'(1);
        frame_t fr     = (asm_m[i] & ~(mask << (ch_m[i] * c.w)))
                       | ((frame_t'(wd_i) & mask) << (ch_m[i] * c.w));
        if (rst_i) begin
            acc_m[i] = 0; ch_m[i] = 0; asm_m[i] = '0; last_m[i] = '0; audio_m[i] = '0;
            ovf_m[i] = 0; und_m[i] = 0; aw_m[i] = 0;
            q_m[i].delete();
            return;
        end
        if (do_pop) begin
            audio_m[i] = q_m[i].pop_front();
            last_m[i]  = audio_m[i];
        end else if (tick) begin
            audio_m[i] = (c.hold != 0) ? last_m[i] : '0;
        end
        if (accept) q_m[i].push_back(fr);
        if (clr_i) begin ovf_m[i] = 0; und_m[i] = 0; end
        if (commit && !accept) ovf_m[i] = 1;
        if (tick && !do_pop)   und_m[i] = 1;
        aw_m[i] = tick;
        if (wr_e) asm_m[i] = fr;
        if (frst_i)    ch_m[i] = 0;
        else if (wr_i) ch_m[i] = (ch_m[i] == c.c - 1) ? 0 : ch_m[i] + 1;
        acc_m[i] += (acc_m[i] < 0) ? c.rate_hz : (c.rate_hz - c.clk_hz);
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i, rst[i], en[i], wr[i], frst[i], clr[i], wd[i]);
        if (rst[0] && rst[1]) model_ok = 1'b1;
    end

    // ---------------- comparison ----------------
    task automatic check(string name, frame_t act, frame_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic frame_t dut_audio(int i);
        return (i == 0) ? frame_t'(bus0.audio) : frame_t'(bus1.audio);
    endfunction

    function automatic int dut_level(int i);
        return (i == 0) ? int'(bus0.level) : int'(bus1.level);
    endfunction

    // {full, overflow, underrun, audio_w}
    function automatic logic [3:0] dut_flags(int i);
        return (i == 0) ? {bus0.full, bus0.overflow, bus0.underrun, bus0.audio_w}
                        : {bus1.full, bus1.overflow, bus1.underrun, bus1.audio_w};
    endfunction

    task automatic cmp(int i);
        cfg_t       c  = cfg(i);
        int         sz = q_m[i].size();
        logic [3:0] f  = dut_flags(i);
        check($sformatf("i%0d_level", i),    frame_t'(dut_level(i)), frame_t'(sz));
        check($sformatf("i%0d_full", i),     frame_t'(f[3]), frame_t'(sz == c.d));
        check($sformatf("i%0d_overflow", i), frame_t'(f[2]), frame_t'(ovf_m[i]));
        check($sformatf("i%0d_underrun", i), frame_t'(f[1]), frame_t'(und_m[i]));
        check($sformatf("i%0d_audio_w", i),  frame_t'(f[0]), frame_t'(aw_m[i]));
        check($sformatf("i%0d_audio", i),    dut_audio(i), audio_m[i]);
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            cmp(0);
            cmp(1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int i = 0; i < 2; i++) begin
            en[i] = 0; wr[i] = 0; frst[i] = 0; clr[i] = 0; rst[i] = 0; wd[i] = '0;
        end
    endtask

    task automatic put(int i, logic [31:0] d);
        wr[i] = 1; wd[i] = d;
        cyc();
        wr[i] = 0;
    endtask

    task automatic pulse_rst(int i);
        rst[i] = 1;
        cyc();
        rst[i] = 0;
    endtask

    task automatic wait_aw(int i, string nm);
        bit seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            cyc();
            seen = dut_flags(i)[0];
        end
        check({nm, "_tick_timeout"}, frame_t'(seen), frame_t'(1));
    endtask

    function automatic logic [31:0] sample(int i, int k, int j);
        if (i == 0) return (j == 0) ? 32'hA000 + k : 32'hB000 + k;
        return 32'h100000 * (j + 1) + k;
    endfunction

    function automatic frame_t mk(int i, int k);
        cfg_t   c = cfg(i);
        frame_t r = '0;
        for (int j = 0; j < c.c; j++) r |= frame_t'(sample(i, k, j)) << (j * c.w);
        return r;
    endfunction

    task automatic put_frame(int i, int k);
        for (int j = 0; j < cfg(i).c; j++) put(i, sample(i, k, j));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int cnt, last_n, min_sp, max_sp, ep, wp;
        idle();
        rst[0] = 1; rst[1] = 1;
        cyc(); cyc();
        rst[0] = 0; rst[1] = 0;

        check("rst_level", frame_t'(dut_level(0)), '0);
        check("rst_flags", frame_t'(dut_flags(0)), '0);
        check("rst_audio", dut_audio(1), '0);

        // two samples form one frame; tick pops it
        put(0, 32'h1111); put(0, 32'h2222);
        check("f1_level", frame_t'(dut_level(0)), frame_t'(1));
        en[0] = 1;
        wait_aw(0, "f1");
        en[0] = 0;
        check("f1_audio", dut_audio(0), frame_t'(32'h22221111));
        check("f1_level_after", frame_t'(dut_level(0)), '0);
        check("f1_underrun", frame_t'(dut_flags(0)[1]), '0);

        // 17 frames into a 16-deep FIFO
        for (int k = 0; k < 17; k++) put_frame(0, k);
        check("ovf_level", frame_t'(dut_level(0)), frame_t'(16));
        check("ovf_full_ovf", frame_t'(dut_flags(0)[3:2]), frame_t'(2'b11));
        en[0] = 1;
        for (int k = 0; k < 16; k++) begin
            wait_aw(0, "drain");
            check($sformatf("drain_%0d", k), dut_audio(0), mk(0, k));
        end
        en[0] = 0;
        check("drain_level", frame_t'(dut_level(0)), '0);
        check("drain_underrun", frame_t'(dut_flags(0)[1]), '0);

        // hold-last on underrun
        put(0, 32'h5555); put(0, 32'hAAAA);
        en[0] = 1;
        wait_aw(0, "hold_pop");
        check("hold_pop", dut_audio(0), frame_t'(32'hAAAA5555));
        wait_aw(0, "hold_empty");
        en[0] = 0;
        check("hold_audio", dut_audio(0), frame_t'(32'hAAAA5555));
        check("hold_underrun", frame_t'(dut_flags(0)[1]), frame_t'(1));
        clr[0] = 1; cyc(); clr[0] = 0;
        check("clr_flags", frame_t'(dut_flags(0)[2:1]), '0);

        // frame_rst discards a partial frame
        put(0, 32'h7777);
        frst[0] = 1; cyc(); frst[0] = 0;
        put(0, 32'h0001); put(0, 32'h0002);
        check("frst_level", frame_t'(dut_level(0)), frame_t'(1));
        en[0] = 1;
        wait_aw(0, "frst");
        en[0] = 0;
        check("frst_audio", dut_audio(0), frame_t'(32'h00020001));

        // tick rate: exactly RATE ticks per CLK cycles starting right after reset
        en[0] = 1;
        pulse_rst(0);
        cnt = 0; last_n = -1; min_sp = 1 << 30; max_sp = 0;
        for (int n = 0; n < CK0; n++) begin
            cyc();
            if (dut_flags(0)[0]) begin
                cnt++;
                if (last_n >= 0) begin
                    if (n - last_n < min_sp) min_sp = n - last_n;
                    if (n - last_n > max_sp) max_sp = n - last_n;
                end
                last_n = n;
            end
        end
        en[0] = 0;
        check("rate_count", frame_t'(cnt), frame_t'(R0));
        check("rate_min_spacing", frame_t'(min_sp), frame_t'(CK0 / R0));
        check("rate_max_spacing", frame_t'(max_sp), frame_t'(CK0 / R0 + 1));

        // zero-fill on underrun, 4x24 configuration
        pulse_rst(1);
        put_frame(1, 'h50);
        en[1] = 1;
        wait_aw(1, "zero_pop");
        check("zero_pop", dut_audio(1), mk(1, 'h50));
        wait_aw(1, "zero_empty");
        en[1] = 0;
        check("zero_audio", dut_audio(1), '0);
        check("zero_underrun", frame_t'(dut_flags(1)[1]), frame_t'(1));

        // commit coincident with pop while full
        pulse_rst(1);
        for (int k = 0; k < 4; k++) put_frame(1, k);
        check("full4_level", frame_t'(dut_level(1)), frame_t'(4));
        check("full4_full", frame_t'(dut_flags(1)[3]), frame_t'(1));
        for (int j = 0; j < 3; j++) put(1, sample(1, 4, j));
        for (int k = 0; k < 100 && acc_m[1] < 0; k++) cyc();
        check("coinc_wait_timeout", frame_t'(acc_m[1] >= 0), frame_t'(1));
        wr[1] = 1; wd[1] = sample(1, 4, 3); en[1] = 1;
        cyc();
        wr[1] = 0; en[1] = 0;
        check("coinc_level", frame_t'(dut_level(1)), frame_t'(4));
        check("coinc_overflow", frame_t'(dut_flags(1)[2]), '0);
        check("coinc_audio", dut_audio(1), mk(1, 0));
        en[1] = 1;
        for (int k = 1; k <= 4; k++) begin
            wait_aw(1, "coinc_drain");
            check($sformatf("coinc_drain_%0d", k), dut_audio(1), mk(1, k));
        end
        en[1] = 0;
        check("coinc_drained", frame_t'(dut_level(1)), '0);

        // randomized traffic against the model
        for (int seg = 0; seg < 20; seg++) begin
            ep = (seg % 3 == 0) ? 0 : (seg % 3 == 1) ? 100 : 20;
            wp = (seg % 4 == 0) ? 5 : 60;
            for (int n = 0; n < 200; n++) begin
                for (int i = 0; i < 2; i++) begin
                    en[i]   = ($urandom_range(99) < ep);
                    wr[i]   = ($urandom_range(99) < wp);
                    wd[i]   = $urandom;
                    frst[i] = ($urandom_range(99) < 2);
                    clr[i]  = ($urandom_range(99) < 3);
                    rst[i]  = ($urandom_range(999) < 2);
                end
                cyc();
            end
        end
        idle();
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
